rf_wb_scheduler: RTL and testbench

//  Write-back arbiter and scoreboard in front of the Reg_File single write port.

---
 rtl/rf_wb_scheduler.sv | 109 ++++++++++
 tb/tb_rf_wb_scheduler.sv | 227 ++++++++++++++++++++++
 2 files changed

// File: rtl/rf_wb_scheduler.sv
// Write-back arbiter and long-latency scoreboard in front of the register file's single write port.
// ALU has fixed priority; a starving LSU result is forced through after STARVE_MAX blocked cycles.
module rf_wb_scheduler #(
  parameter int AWIDTH     = 5,
  parameter int DWIDTH     = 32,
  parameter int STARVE_MAX = 3,
  parameter int MAX_PEND   = 4
) (
  input  logic                            clk,
  input  logic                            rst_n,
  input  logic                            issue_valid,
  input  logic                            issue_long,
  input  logic [AWIDTH-1:0]               issue_rd,
  input  logic [AWIDTH-1:0]               issue_rs1,
  input  logic [AWIDTH-1:0]               issue_rs2,
  output logic                            issue_stall,
  input  logic                            alu_wb_valid,
  input  logic [AWIDTH-1:0]               alu_wb_rd,
  input  logic [DWIDTH-1:0]               alu_wb_data,
  output logic                            alu_wb_ready,
  input  logic                            lsu_wb_valid,
  input  logic [AWIDTH-1:0]               lsu_wb_rd,
  input  logic [DWIDTH-1:0]               lsu_wb_data,
  output logic                            lsu_wb_ready,
  output logic                            rf_we,
  output logic [AWIDTH-1:0]               rf_waddr,
  output logic [DWIDTH-1:0]               rf_wdata,
  output logic [$clog2(MAX_PEND+1)-1:0]   pend_cnt
);

  localparam int NREG = 2 ** AWIDTH;
  localparam int SW   = $clog2(STARVE_MAX + 1);
  localparam int PW   = $clog2(MAX_PEND + 1);

  logic [SW-1:0]   starveCnt;
  logic [NREG-1:0] pendMask;
  logic [NREG-1:0] setMask;
  logic [NREG-1:0] clrMask;
  logic            forceLsu;
  logic            lsuAccept;
  logic            aluAccept;
  logic            longAccept;
  logic            pendRs1;
  logic            pendRs2;
  logic            pendRd;

  assign forceLsu     = lsu_wb_valid & (starveCnt == SW'(STARVE_MAX));
  assign lsu_wb_ready = lsu_wb_valid & (~alu_wb_valid | forceLsu);
  assign alu_wb_ready = ~forceLsu;
  assign lsuAccept    = lsu_wb_valid & lsu_wb_ready;
  assign aluAccept    = alu_wb_valid & alu_wb_ready;

  // x0 is hard-wired, so it never blocks issue even if a long op targets it.
  assign pendRs1 = (issue_rs1 != '0) & pendMask[issue_rs1];
  assign pendRs2 = (issue_rs2 != '0) & pendMask[issue_rs2];
  assign pendRd  = (issue_rd  != '0) & pendMask[issue_rd];

  assign issue_stall = issue_valid & (pendRs1 | pendRs2 | pendRd
                       | (issue_long & (pend_cnt == PW'(MAX_PEND))));
  assign longAccept  = issue_valid & ~issue_stall & issue_long;

  always_comb begin
    // NOTE: every always_comb output gets a default first so no path leaves it unassigned (no latch).
    setMask = '0;
    clrMask = '0;
    if (lsuAccept)                      clrMask[lsu_wb_rd] = 1'b1;
    if (longAccept && issue_rd != '0)   setMask[issue_rd]  = 1'b1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rf_we     <= 1'b0;
      rf_waddr  <= '0;
      rf_wdata  <= '0;
      pend_cnt  <= '0;
      starveCnt <= '0;
      // NOTE: the scoreboard is a flop vector, not a RAM, so it is reset with everything else.
      pendMask  <= '0;
    end else begin
      // NOTE: sequential state uses non-blocking assignments so all registers update from pre-edge values.
      pendMask <= (pendMask & ~clrMask) | setMask;

      case ({longAccept, lsuAccept})
        2'b10:   pend_cnt <= pend_cnt + PW'(1);
        2'b01:   pend_cnt <= pend_cnt - PW'(1);
        default: pend_cnt <= pend_cnt;
      endcase

      if (lsu_wb_valid && !lsu_wb_ready)
        starveCnt <= (starveCnt == SW'(STARVE_MAX)) ? starveCnt : starveCnt + SW'(1);
      else
        starveCnt <= '0;

      // Grants are mutually exclusive; x0 writes handshake but never strobe the port.
      if (lsuAccept) begin
        rf_we    <= (lsu_wb_rd != '0);
        rf_waddr <= lsu_wb_rd;
        rf_wdata <= lsu_wb_data;
      end else if (aluAccept) begin
        rf_we    <= (alu_wb_rd != '0);
        rf_waddr <= alu_wb_rd;
        rf_wdata <= alu_wb_data;
      end else begin
        rf_we    <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_rf_wb_scheduler.sv
// Randomized self-checking bench for rf_wb_scheduler against a queue-based reference model.
// Directed sequences cover reset, priority/aging, RAW stall, pend-count limit and x0 writes.
module tb_rf_wb_scheduler;

  localparam int STARVE_MAX = 3;
  localparam int MAX_PEND   = 4;

  logic        clk;
  logic        rst_n;
  logic        issue_valid, issue_long;
  logic [4:0]  issue_rd, issue_rs1, issue_rs2;
  logic        issue_stall;
  logic        alu_wb_valid;
  logic [4:0]  alu_wb_rd;
  logic [31:0] alu_wb_data;
  logic        alu_wb_ready;
  logic        lsu_wb_valid;
  logic [4:0]  lsu_wb_rd;
  logic [31:0] lsu_wb_data;
  logic        lsu_wb_ready;
  logic        rf_we;
  logic [4:0]  rf_waddr;
  logic [31:0] rf_wdata;
  logic [2:0]  pend_cnt;

  rf_wb_scheduler #(
    .AWIDTH(5), .DWIDTH(32), .STARVE_MAX(STARVE_MAX), .MAX_PEND(MAX_PEND)
  ) dut (
    .clk(clk), .rst_n(rst_n),
    .issue_valid(issue_valid), .issue_long(issue_long), .issue_rd(issue_rd),
    .issue_rs1(issue_rs1), .issue_rs2(issue_rs2), .issue_stall(issue_stall),
    .alu_wb_valid(alu_wb_valid), .alu_wb_rd(alu_wb_rd), .alu_wb_data(alu_wb_data),
    .alu_wb_ready(alu_wb_ready),
    .lsu_wb_valid(lsu_wb_valid), .lsu_wb_rd(lsu_wb_rd), .lsu_wb_data(lsu_wb_data),
    .lsu_wb_ready(lsu_wb_ready),
    .rf_we(rf_we), .rf_waddr(rf_waddr), .rf_wdata(rf_wdata), .pend_cnt(pend_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int nChecks = 0;
  int nFails  = 0;

  // Reference model: outstanding long ops as a list of destinations.
  logic [4:0]  outstanding[$];
  int          blockedCycles;
  logic        expWe;
  logic [4:0]  expAddr;
  logic [31:0] expData;
  logic        lastLsuAcc;
  logic        lastStall;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    nChecks++;
    if (obs !== exp) begin
      nFails++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, obs, exp, $time);
    end
  endtask

  function automatic bit isPend(input logic [4:0] r);
    if (r == 5'd0) return 1'b0;
    foreach (outstanding[i]) if (outstanding[i] == r) return 1'b1;
    return 1'b0;
  endfunction

  task automatic modelReset();
    outstanding.delete();
    blockedCycles = 0;
    expWe = 1'b0; expAddr = '0; expData = '0;
    lastLsuAcc = 1'b0;
  endtask

  // Called at posedge+1: drives one cycle of inputs, checks comb outputs, clocks, checks rf_*.
  task automatic step(input logic iv, input logic il, input logic [4:0] ird,
                      input logic [4:0] irs1, input logic [4:0] irs2,
                      input logic av, input logic [4:0] ard, input logic [31:0] adata,
                      input logic lv, input logic [4:0] lrd, input logic [31:0] ldata);
    bit frc, eLsuRdy, eAluRdy, eStall, aluAcc, lsuAcc;
    issue_valid = iv; issue_long = il; issue_rd = ird; issue_rs1 = irs1; issue_rs2 = irs2;
    alu_wb_valid = av; alu_wb_rd = ard; alu_wb_data = adata;
    lsu_wb_valid = lv; lsu_wb_rd = lrd; lsu_wb_data = ldata;
    #1;
    frc     = lv && (blockedCycles == STARVE_MAX);
    eLsuRdy = lv && (!av || frc);
    eAluRdy = !frc;
    eStall  = iv && (isPend(irs1) || isPend(irs2) || isPend(ird)
                     || (il && outstanding.size() == MAX_PEND));
    check("lsu_wb_ready", 32'(lsu_wb_ready), 32'(eLsuRdy));
    check("alu_wb_ready", 32'(alu_wb_ready), 32'(eAluRdy));
    check("issue_stall",  32'(issue_stall),  32'(eStall));
    check("pend_cnt",     32'(pend_cnt),     32'(outstanding.size()));

    aluAcc = av && eAluRdy;
    lsuAcc = lv && eLsuRdy;
    if (lsuAcc) begin
      expWe = (lrd != 0); expAddr = lrd; expData = ldata;
      for (int i = 0; i < outstanding.size(); i++)
        if (outstanding[i] == lrd) begin outstanding.delete(i); break; end
    end else if (aluAcc) begin
      expWe = (ard != 0); expAddr = ard; expData = adata;
    end else begin
      expWe = 1'b0;
    end
    if (lv && !lsuAcc) blockedCycles = (blockedCycles < STARVE_MAX) ? blockedCycles + 1 : STARVE_MAX;
    else               blockedCycles = 0;
    if (iv && !eStall && il) outstanding.push_back(ird);
    lastLsuAcc = lsuAcc;
    lastStall  = eStall;

    @(posedge clk); #1;
    check("rf_we", 32'(rf_we), 32'(expWe));
    if (expWe) begin
      check("rf_waddr", 32'(rf_waddr), 32'(expAddr));
      check("rf_wdata", rf_wdata, expData);
    end
  endtask

  task automatic idle();
    step(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
  endtask

  // Return every outstanding op through the LSU, bounded.
  task automatic drain();
    for (int n = 0; n < 20 && outstanding.size() > 0; n++)
      step(0, 0, 0, 0, 0, 0, 0, 0, 1, outstanding[0], $urandom);
    check("drain_empty", 32'(outstanding.size()), 32'd0);
  endtask

  logic        lv, lsuHold;
  logic [4:0]  lrd;
  logic [31:0] ldata;
  int          idx;

  initial begin
    rst_n = 1'b0;
    issue_valid = 0; issue_long = 0; issue_rd = 0; issue_rs1 = 0; issue_rs2 = 0;
    alu_wb_valid = 0; alu_wb_rd = 0; alu_wb_data = 0;
    lsu_wb_valid = 0; lsu_wb_rd = 0; lsu_wb_data = 0;
    modelReset();
    @(posedge clk); @(posedge clk); #1;
    check("rst_rf_we", 32'(rf_we), 32'd0);
    check("rst_waddr", 32'(rf_waddr), 32'd0);
    check("rst_wdata", rf_wdata, 32'd0);
    check("rst_pend_cnt", 32'(pend_cnt), 32'd0);
    rst_n = 1'b1;

    // ALU write rd=5
    step(0, 0, 0, 0, 0, 1, 5'd5, 32'hA5A5_A5A5, 0, 0, 0);
    check("t2_we", 32'(rf_we), 32'd1);
    check("t2_addr", 32'(rf_waddr), 32'd5);
    check("t2_data", rf_wdata, 32'hA5A5_A5A5);

    // ALU write to x0: handshake only
    step(0, 0, 0, 0, 0, 1, 5'd0, 32'hFFFF_FFFF, 0, 0, 0);
    check("t6_we", 32'(rf_we), 32'd0);

    // LSU aging: ALU wins three cycles, LSU forced on the fourth
    step(1, 1, 5'd9, 0, 0, 0, 0, 0, 0, 0, 0);
    for (int c = 0; c < 4; c++) begin
      step(0, 0, 0, 0, 0, 1, 5'd3, 32'h100 + c, 1, 5'd9, 32'hCAFE_0009);
      check("t3_lsu_acc", 32'(lastLsuAcc), 32'(c == 3));
    end
    check("t3_rf_addr", 32'(rf_waddr), 32'd9);
    step(0, 0, 0, 0, 0, 1, 5'd3, 32'h200, 0, 0, 0);

    // RAW stall on rd=7 until the LSU returns it
    step(1, 1, 5'd7, 0, 0, 0, 0, 0, 0, 0, 0);
    step(1, 0, 5'd1, 5'd7, 5'd2, 0, 0, 0, 0, 0, 0);
    check("t4_stall", 32'(lastStall), 32'd1);
    step(1, 0, 5'd1, 5'd7, 5'd2, 0, 0, 0, 1, 5'd7, 32'h7777_7777);
    check("t4_stall_acc", 32'(lastStall), 32'd1);
    step(1, 0, 5'd1, 5'd7, 5'd2, 0, 0, 0, 0, 0, 0);
    check("t4_released", 32'(lastStall), 32'd0);

    // Pend limit: four long ops (one to x0), fifth stalls, short op passes
    drain();
    for (int r = 0; r < 4; r++) step(1, 1, 5'(r * 2), 0, 0, 0, 0, 0, 0, 0, 0);
    check("t5_pend4", 32'(pend_cnt), 32'd4);
    step(1, 1, 5'd20, 5'd21, 5'd22, 0, 0, 0, 0, 0, 0);
    check("t5_long_stall", 32'(lastStall), 32'd1);
    step(1, 0, 5'd20, 5'd21, 5'd22, 0, 0, 0, 0, 0, 0);
    check("t5_short_ok", 32'(lastStall), 32'd0);
    drain();

    // Randomized traffic
    lsuHold = 1'b0; lv = 0; lrd = 0; ldata = 0;
    for (int cyc = 0; cyc < 2000; cyc++) begin
      if (!lsuHold) begin
        if (outstanding.size() > 0 && $urandom_range(1, 0) == 1) begin
          idx = $urandom_range(outstanding.size() - 1, 0);
          lv = 1'b1; lrd = outstanding[idx]; ldata = $urandom;
        end else begin
          lv = 1'b0;
        end
      end
      step($urandom_range(1, 0) == 1, $urandom_range(2, 0) == 0, 5'($urandom_range(7, 0)),
           5'($urandom_range(7, 0)), 5'($urandom_range(7, 0)),
           $urandom_range(2, 0) != 0, 5'($urandom_range(7, 0)), $urandom,
           lv, lrd, ldata);
      lsuHold = lv && !lastLsuAcc;
    end

    // Reset mid-stream with a pending register
    step(1, 1, 5'd6, 0, 0, 0, 0, 0, 0, 0, 0);
    issue_valid = 1; issue_long = 0; issue_rd = 5'd1; issue_rs1 = 5'd6; issue_rs2 = 0;
    alu_wb_valid = 1; alu_wb_rd = 5'd4; alu_wb_data = 32'h1234;
    lsu_wb_valid = 0;
    rst_n = 1'b0;
    #1;
    check("t1_we", 32'(rf_we), 32'd0);
    check("t1_addr", 32'(rf_waddr), 32'd0);
    check("t1_data", rf_wdata, 32'd0);
    check("t1_pend", 32'(pend_cnt), 32'd0);
    check("t1_stall", 32'(issue_stall), 32'd0);
    modelReset();
    @(posedge clk); #1;
    rst_n = 1'b1;
    step(1, 0, 5'd1, 5'd6, 5'd6, 0, 0, 0, 0, 0, 0);
    idle();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", nChecks, nFails);
    $finish;
  end

endmodule
